icache_line: RTL and testbench

- Parametrised successor to the single-word direct-mapped instruction cache. Sits between the instruction-fetch unit and the memory controller.
- Each line holds 2^OFFSET_BITS words. A miss refills the whole line with sequential word requests.
- A flush input invalidates the entire cache, for example on a fence or a self-modifying store.

---
 rtl/icache_line_pkg.sv | 32 +++
 rtl/icache_line_if.sv | 24 ++
 rtl/icache_line_ram.sv | 52 +++++
 rtl/icache_line.sv | 160 ++++++++++++++++
 tb/tb_icache_line.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/icache_line_pkg.sv
// Shared types, default geometry and pc field-extract helpers for the line-based icache.
package icache_line_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    localparam int unsigned DefIndexBits  = 6;
    localparam int unsigned DefOffsetBits = 2;
    localparam int unsigned DefAddrBits   = 18;

    function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int unsigned index_bits,
                                           input int unsigned offset_bits);
        return (pc >> (offset_bits + 2)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] pc_off(input logic [31:0] pc, input int unsigned offset_bits);
        return (pc >> 2) & ((32'd1 << offset_bits) - 32'd1);
    endfunction

    // Bits at and above addr_bits are masked off; they never take part in the tag compare.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int unsigned index_bits,
                                           input int unsigned offset_bits,
                                           input int unsigned addr_bits);
        int unsigned low;
        low = index_bits + offset_bits + 2;
        return (pc >> low) & ((32'd1 << (addr_bits - low)) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_line_if.sv
// Fetch-side and memory-side handshake bundle of the line icache.
interface icache_line_if;

    logic        if_valid;
    logic [31:0] pc_from_if;
    logic        flush;
    logic        inst_enable;
    logic [31:0] inst_to_if;
    logic        addr_enable;
    logic [31:0] addr_to_mem;
    logic        mem_valid;
    logic [31:0] inst_from_mem;

    modport slave (
        input  if_valid, pc_from_if, flush, mem_valid, inst_from_mem,
        output inst_enable, inst_to_if, addr_enable, addr_to_mem
    );

    modport master (
        output if_valid, pc_from_if, flush, mem_valid, inst_from_mem,
        input  inst_enable, inst_to_if, addr_enable, addr_to_mem
    );

endinterface

// File: rtl/icache_line_ram.sv
// Valid/tag/data storage: one write port (word, line validate, invalidate-all) and async read.
module icache_line_ram #(
    parameter int unsigned INDEX_BITS  = 6,
    parameter int unsigned OFFSET_BITS = 2,
    parameter int unsigned TAG_BITS    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INDEX_BITS-1:0]  rd_idx,
    input  logic [OFFSET_BITS-1:0] rd_off,
    output logic                   rd_valid,
    output logic [TAG_BITS-1:0]    rd_tag,
    output logic [31:0]            rd_word,
    input  logic                   wr_en,
    input  logic [INDEX_BITS-1:0]  wr_idx,
    input  logic [OFFSET_BITS-1:0] wr_off,
    input  logic [31:0]            wr_word,
    input  logic                   val_en,
    input  logic [TAG_BITS-1:0]    val_tag,
    input  logic                   inv_all
);
    localparam int unsigned Lines = 2 ** INDEX_BITS;
    localparam int unsigned Words = 2 ** OFFSET_BITS;

    logic [Lines-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [Lines];
    logic [31:0]         data_q [Lines][Words];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (val_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_word;
        end
        if (val_en) begin
            tag_q[wr_idx] <= val_tag;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_line.sv
// Direct-mapped multi-word-line instruction cache with sequential line refill and flush.
// Optional hit/miss counters are built when ICACHE_PERF_EN is defined.
module icache_line
    import icache_line_pkg::*;
#(
    parameter int unsigned INDEX_BITS  = DefIndexBits,
    parameter int unsigned OFFSET_BITS = DefOffsetBits,
    parameter int unsigned ADDR_BITS   = DefAddrBits
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    icache_line_if.slave bus
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int unsigned TagBits = ADDR_BITS - INDEX_BITS - OFFSET_BITS - 2;

    logic [INDEX_BITS-1:0]  idx, lidx_q, lidx_d;
    logic [OFFSET_BITS-1:0] off, cnt_q, cnt_d;
    logic [TagBits-1:0]     tag, ltag_q, ltag_d, rd_tag;
    logic                   rd_valid, hit, wr_en, val_en, inv_all, hit_ok, start_miss;
    logic [31:0]            rd_word;
    state_e                 state_q, state_d;
    logic                   inst_enable_q, inst_enable_d, addr_enable_q, addr_enable_d;
    logic [31:0]            inst_q, inst_d, addr_q, addr_d;

    assign idx = INDEX_BITS'(pc_idx(bus.pc_from_if, INDEX_BITS, OFFSET_BITS));
    assign off = OFFSET_BITS'(pc_off(bus.pc_from_if, OFFSET_BITS));
    assign tag = TagBits'(pc_tag(bus.pc_from_if, INDEX_BITS, OFFSET_BITS, ADDR_BITS));
    assign hit = rd_valid && (rd_tag == tag);

    icache_line_ram #(
        .INDEX_BITS (INDEX_BITS),
        .OFFSET_BITS(OFFSET_BITS),
        .TAG_BITS   (TagBits)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx),
        .rd_off  (off),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_word (rd_word),
        .wr_en   (wr_en),
        .wr_idx  (lidx_q),
        .wr_off  (cnt_q),
        .wr_word (bus.inst_from_mem),
        .val_en  (val_en),
        .val_tag (ltag_q),
        .inv_all (inv_all)
    );

    // With rdy low nothing advances; only the hit strobe is forced low.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        ltag_d        = ltag_q;
        lidx_d        = lidx_q;
        inst_enable_d = 1'b0;
        inst_d        = inst_q;
        addr_enable_d = addr_enable_q;
        addr_d        = addr_q;
        wr_en         = 1'b0;
        val_en        = 1'b0;
        inv_all       = 1'b0;
        hit_ok        = 1'b0;
        start_miss    = 1'b0;
        if (rdy) begin
            inv_all = bus.flush;
            unique case (state_q)
                StIdle: begin
                    if (bus.if_valid && !bus.flush) begin
                        if (hit) begin
                            inst_enable_d = 1'b1;
                            inst_d        = rd_word;
                            hit_ok        = 1'b1;
                        end else begin
                            state_d    = StReq;
                            ltag_d     = tag;
                            lidx_d     = idx;
                            cnt_d      = '0;
                            start_miss = 1'b1;
                        end
                    end
                end
                StReq: begin
                    if (bus.flush) begin
                        state_d       = StIdle;
                        addr_enable_d = 1'b0;
                    end else begin
                        addr_enable_d = 1'b1;
                        addr_d  = {bus.pc_from_if[31:ADDR_BITS], ltag_q, lidx_q, cnt_q, 2'b00};
                        state_d = StWait;
                    end
                end
                StWait: begin
                    if (bus.flush) begin
                        state_d       = StIdle;
                        addr_enable_d = 1'b0;
                    end else if (bus.mem_valid) begin
                        wr_en         = 1'b1;
                        addr_enable_d = 1'b0;
                        if (&cnt_q) begin
                            val_en  = 1'b1;
                            state_d = StIdle;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = StReq;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            ltag_q        <= '0;
            lidx_q        <= '0;
            inst_enable_q <= 1'b0;
            inst_q        <= '0;
            addr_enable_q <= 1'b0;
            addr_q        <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ltag_q        <= ltag_d;
            lidx_q        <= lidx_d;
            inst_enable_q <= inst_enable_d;
            inst_q        <= inst_d;
            addr_enable_q <= addr_enable_d;
            addr_q        <= addr_d;
        end
    end

    assign bus.inst_enable = inst_enable_q;
    assign bus.inst_to_if  = inst_q;
    assign bus.addr_enable = addr_enable_q;
    assign bus.addr_to_mem = addr_q;

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_ok) hit_count <= hit_count + 32'd1;
            if (start_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_line.sv
// Directed self-checking bench for icache_line; covers perf counters when ICACHE_PERF_EN is set.
module tb_icache_line;

    logic clk = 1'b0;
    logic rst, rdy;
    int   n_checks = 0;
    int   n_errs   = 0;

    icache_line_if bus ();

`ifdef ICACHE_PERF_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_line dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
`ifdef ICACHE_PERF_EN
        ,
        .hit_count (hit_count),
        .miss_count(miss_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        bus.if_valid   = 1'b1;
        bus.pc_from_if = pc;
        step();
    endtask

    // Wait for a request, check its address, return one word.
    task automatic serve_word(input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (!bus.addr_enable && n < 20) begin
            step();
            n++;
        end
        if (!bus.addr_enable) begin
            check("req_timeout", 32'd0, 32'd1);
            return;
        end
        check("req_addr", bus.addr_to_mem, addr);
        bus.mem_valid     = 1'b1;
        bus.inst_from_mem = data;
        step();
        bus.mem_valid = 1'b0;
        check("ack_drop", {31'd0, bus.addr_enable}, 32'd0);
    endtask

    task automatic serve_line(input logic [31:0] base, input logic [31:0] d0,
                              input logic [31:0] dstep);
        for (int i = 0; i < 4; i++) begin
            serve_word(base + 32'(4 * i), d0 + 32'(i) * dstep);
        end
    endtask

    initial begin
        rst = 1'b1;
        rdy = 1'b1;
        bus.if_valid = 1'b0;
        bus.pc_from_if = '0;
        bus.flush = 1'b0;
        bus.mem_valid = 1'b0;
        bus.inst_from_mem = '0;
        step();
        step();
        rst = 1'b0;
        check("rst_inst_en", {31'd0, bus.inst_enable}, 32'd0);
        check("rst_inst", bus.inst_to_if, 32'd0);
        check("rst_addr_en", {31'd0, bus.addr_enable}, 32'd0);
        check("rst_addr", bus.addr_to_mem, 32'd0);

        // Cold miss on line 0 and refill.
        fetch(32'h0);
        check("miss0_en", {31'd0, bus.inst_enable}, 32'd0);
        serve_line(32'h0, 32'h11, 32'h11);
        fetch(32'h8);
        check("hit8_en", {31'd0, bus.inst_enable}, 32'd1);
        check("hit8_data", bus.inst_to_if, 32'h33);

        // Back-to-back hits across the line.
        for (int i = 0; i < 4; i++) begin
            fetch(32'(4 * i));
            check("b2b_en", {31'd0, bus.inst_enable}, 32'd1);
            check("b2b_data", bus.inst_to_if, 32'h11 * 32'(i + 1));
            check("b2b_no_req", {31'd0, bus.addr_enable}, 32'd0);
        end
        bus.if_valid = 1'b0;
        step();
        check("idle_en", {31'd0, bus.inst_enable}, 32'd0);

        // Conflict: tag 1 at the same index evicts line 0.
        fetch(32'h400);
        check("conf_miss", {31'd0, bus.inst_enable}, 32'd0);
        serve_line(32'h400, 32'hA1, 32'h1);
        fetch(32'h404);
        check("conf_hit", bus.inst_to_if, 32'hA2);
        fetch(32'h0);
        check("evict_miss", {31'd0, bus.inst_enable}, 32'd0);
        serve_line(32'h0, 32'h51, 32'h1);
        fetch(32'h0);
        check("refill_hit", bus.inst_to_if, 32'h51);

        // Flush mid-refill after two words.
        fetch(32'h10);
        serve_word(32'h10, 32'h71);
        serve_word(32'h14, 32'h72);
        step();
        check("wait_req", {31'd0, bus.addr_enable}, 32'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_abort", {31'd0, bus.addr_enable}, 32'd0);
        bus.if_valid = 1'b0;
        bus.mem_valid = 1'b1;
        bus.inst_from_mem = 32'hBAD;
        step();
        bus.mem_valid = 1'b0;
        check("stray_ign", {31'd0, bus.addr_enable}, 32'd0);
        fetch(32'h10);
        check("reflush_miss", {31'd0, bus.inst_enable}, 32'd0);
        serve_line(32'h10, 32'h81, 32'h1);
        fetch(32'h18);
        check("reflush_hit", bus.inst_to_if, 32'h83);

        // Freeze in WAIT; line 0 was invalidated by the flush.
        fetch(32'h0);
        check("flushed_miss", {31'd0, bus.inst_enable}, 32'd0);
        serve_word(32'h0, 32'h61);
        step();
        rdy = 1'b0;
        bus.mem_valid = 1'b1;
        bus.inst_from_mem = 32'hDEAD;
        for (int i = 0; i < 5; i++) begin
            step();
            check("frz_en", {31'd0, bus.inst_enable}, 32'd0);
            check("frz_req", {31'd0, bus.addr_enable}, 32'd1);
        end
        rdy = 1'b1;
        bus.mem_valid = 1'b0;
        serve_word(32'h4, 32'h62);
        serve_word(32'h8, 32'h63);
        serve_word(32'hC, 32'h64);
        fetch(32'h4);
        check("frz_hit4", bus.inst_to_if, 32'h62);
        fetch(32'h0);
        check("frz_hit0", bus.inst_to_if, 32'h61);

        // One miss, seven hits, then a flush that collides with a hit.
        rst = 1'b1;
        step();
        rst = 1'b0;
        fetch(32'h20);
        check("pf_miss", {31'd0, bus.inst_enable}, 32'd0);
        serve_line(32'h20, 32'h91, 32'h1);
        for (int i = 0; i < 7; i++) begin
            fetch(32'h20 + 32'(4 * (i % 4)));
            check("pf_hit", bus.inst_to_if, 32'h91 + 32'(i % 4));
        end
        bus.flush = 1'b1;
        fetch(32'h20);
        bus.flush = 1'b0;
        check("flush_hit", {31'd0, bus.inst_enable}, 32'd0);
        bus.if_valid = 1'b0;
        step();
`ifdef ICACHE_PERF_EN
        check("hit_count", hit_count, 32'd7);
        check("miss_count", miss_count, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
